// File: rtl/conv_pkg.sv
// conv_pkg: shared types and default geometry for the convolution channel
// scheduler and its partial-sum buffer.
//   sched_state_t : scheduler FSM states
//   *_DEF         : default layer geometry
//   NPIX_DEF      : pixels per output plane (OUT_H*OUT_W)
//   idx_w()       : index width helper, never narrower than one bit
package conv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LAUNCH  = 3'd1,
    ST_COLLECT = 3'd2,
    ST_CLEAR   = 3'd3,
    ST_DRAIN   = 3'd4,
    ST_FIN     = 3'd5
  } sched_state_t;

  localparam int ACC_WIDTH_DEF = 32;
  localparam int OUT_H_DEF     = 3;
  localparam int OUT_W_DEF     = 3;
  localparam int MAX_CIN_DEF   = 4;
  localparam int MAX_COUT_DEF  = 4;
  localparam int NPIX_DEF      = OUT_H_DEF * OUT_W_DEF;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_channel_scheduler_psum.sv
// psum_buffer: NPIX x W partial-sum storage.
//   clk_i   : clock
//   we_i    : write enable (sync)
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (combinational read)
//   rdata_o : read data; zero for addresses beyond NPIX-1
// No reset: contents are always overwritten by the first input channel of a
// plane before being read.
module psum_buffer #(
  parameter int NPIX = 9,
  parameter int W    = 32,
  parameter int AW   = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [NPIX];

  always_ff @(posedge clk_i) begin
    if (we_i && (waddr_i < AW'(NPIX))) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = (raddr_i < AW'(NPIX)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/conv_channel_scheduler.sv
// conv_channel_scheduler: runs the single-window convolution engine once per
// (output channel, input channel) pair, accumulates the per-pixel partial sums
// and streams each finished output plane downstream.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   cfg_cin_i, cfg_cout_i : channel counts, latched on accepted start
//   start_i               : layer start (accepted only when idle)
//   busy_o, done_o, err_o : layer status; err_o sticky until next start
//   eng_start_o/clear_o   : engine pass launch / return-to-idle pulses
//   eng_in_sel_o          : input plane for the pass
//   eng_k_sel_o           : kernel index oc*cin+ic
//   eng_pixel_i/valid_i   : engine pixel stream
//   eng_done_i            : engine pass complete (level until eng_clear_o)
//   res_*                 : valid/ready result stream with plane tag and last
module conv_channel_scheduler
  import conv_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int OUT_H     = OUT_H_DEF,
  parameter int OUT_W     = OUT_W_DEF,
  parameter int MAX_CIN   = MAX_CIN_DEF,
  parameter int MAX_COUT  = MAX_COUT_DEF,
  localparam int NPIX     = OUT_H * OUT_W,
  localparam int PIX_W    = idx_w(NPIX + 1),
  localparam int CIN_W    = idx_w(MAX_CIN + 1),
  localparam int COUT_W   = idx_w(MAX_COUT + 1),
  localparam int IC_W     = idx_w(MAX_CIN),
  localparam int OC_W     = idx_w(MAX_COUT),
  localparam int K_W      = idx_w(MAX_CIN * MAX_COUT)
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [CIN_W-1:0]            cfg_cin_i,
  input  logic [COUT_W-1:0]           cfg_cout_i,
  input  logic                        start_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic                        eng_start_o,
  output logic                        eng_clear_o,
  output logic [IC_W-1:0]             eng_in_sel_o,
  output logic [K_W-1:0]              eng_k_sel_o,
  input  logic signed [ACC_WIDTH-1:0] eng_pixel_i,
  input  logic                        eng_valid_i,
  input  logic                        eng_done_i,
  output logic signed [ACC_WIDTH-1:0] res_data_o,
  output logic                        res_valid_o,
  input  logic                        res_ready_i,
  output logic [OC_W-1:0]             res_oc_o,
  output logic                        res_last_o
);

  sched_state_t      state_q, state_d;
  logic [CIN_W-1:0]  cin_q, cin_d;
  logic [COUT_W-1:0] cout_q, cout_d;
  logic [IC_W-1:0]   ic_q, ic_d;
  logic [OC_W-1:0]   oc_q, oc_d;
  logic [K_W-1:0]    k_q, k_d;
  // pix_q is the write pointer while collecting and the read pointer while draining
  logic [PIX_W-1:0]  pix_q, pix_d;
  logic              err_q, err_d;

  logic                 buf_we;
  logic [ACC_WIDTH-1:0] buf_rdata, buf_wdata;

  logic cfg_bad, pix_full, ic_last, oc_last, pix_lastbeat;

  assign cfg_bad      = (cfg_cin_i == '0) || (cfg_cout_i == '0) ||
                        (cfg_cin_i > CIN_W'(MAX_CIN)) || (cfg_cout_i > COUT_W'(MAX_COUT));
  assign pix_full     = (pix_q == PIX_W'(NPIX));
  assign pix_lastbeat = (pix_q == PIX_W'(NPIX - 1));
  assign ic_last      = (CIN_W'(ic_q) == cin_q - CIN_W'(1));
  assign oc_last      = (COUT_W'(oc_q) == cout_q - COUT_W'(1));

  // first input channel overwrites, later ones accumulate (wrapping add)
  assign buf_wdata = (ic_q == '0) ? eng_pixel_i : buf_rdata + eng_pixel_i;

  psum_buffer #(.NPIX(NPIX), .W(ACC_WIDTH), .AW(PIX_W)) u_psum (
    .clk_i   (clk_i),
    .we_i    (buf_we),
    .waddr_i (pix_q),
    .wdata_i (buf_wdata),
    .raddr_i (pix_q),
    .rdata_o (buf_rdata)
  );

  always_comb begin
    state_d = state_q;
    cin_d   = cin_q;
    cout_d  = cout_q;
    ic_d    = ic_q;
    oc_d    = oc_q;
    k_d     = k_q;
    pix_d   = pix_q;
    err_d   = err_q;
    buf_we  = 1'b0;
    case (state_q)
      ST_IDLE: if (start_i) begin
        cin_d  = cfg_cin_i;
        cout_d = cfg_cout_i;
        ic_d   = '0;
        oc_d   = '0;
        k_d    = '0;
        pix_d  = '0;
        err_d  = cfg_bad;
        state_d = cfg_bad ? ST_FIN : ST_LAUNCH;
      end
      // hold off the launch while the engine still reports a finished pass
      ST_LAUNCH: if (!eng_done_i) state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (eng_valid_i) begin
          if (pix_full) err_d = 1'b1;
          else begin
            buf_we = 1'b1;
            pix_d  = pix_q + PIX_W'(1);
          end
        end
        // count checked after the same-cycle pixel has been taken
        if (eng_done_i) begin
          if (pix_d != PIX_W'(NPIX)) err_d = 1'b1;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        pix_d = '0;
        if (!ic_last) begin
          ic_d    = ic_q + IC_W'(1);
          k_d     = k_q + K_W'(1);
          state_d = ST_LAUNCH;
        end else begin
          ic_d    = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (res_ready_i) begin
        if (pix_lastbeat) begin
          pix_d = '0;
          if (!oc_last) begin
            // k runs oc*cin+ic, so the next plane's first kernel is just k+1
            oc_d    = oc_q + OC_W'(1);
            k_d     = k_q + K_W'(1);
            state_d = ST_LAUNCH;
          end else state_d = ST_FIN;
        end else pix_d = pix_q + PIX_W'(1);
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cin_q   <= '0;
      cout_q  <= '0;
      ic_q    <= '0;
      oc_q    <= '0;
      k_q     <= '0;
      pix_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cin_q   <= cin_d;
      cout_q  <= cout_d;
      ic_q    <= ic_d;
      oc_q    <= oc_d;
      k_q     <= k_d;
      pix_q   <= pix_d;
      err_q   <= err_d;
    end
  end

  assign busy_o       = (state_q != ST_IDLE);
  assign done_o       = (state_q == ST_FIN);
  assign err_o        = err_q;
  assign eng_start_o  = (state_q == ST_LAUNCH) && !eng_done_i;
  assign eng_clear_o  = (state_q == ST_CLEAR);
  assign eng_in_sel_o = ic_q;
  assign eng_k_sel_o  = k_q;
  assign res_valid_o  = (state_q == ST_DRAIN);
  assign res_data_o   = buf_rdata;
  assign res_oc_o     = oc_q;
  assign res_last_o   = (state_q == ST_DRAIN) && pix_lastbeat;

endmodule

// File: tb/tb_conv_channel_scheduler.sv
module tb_conv_channel_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [2:0]  cfg_cin = '0, cfg_cout = '0;
  logic        start = 1'b0;
  logic        busy, done, err, eng_start, eng_clear;
  logic [1:0]  eng_in_sel;
  logic [3:0]  eng_k_sel;
  logic signed [31:0] eng_pixel = '0;
  logic        eng_valid = 1'b0, eng_done = 1'b0;
  logic signed [31:0] res_data;
  logic        res_valid, res_ready = 1'b1;
  logic [1:0]  res_oc;
  logic        res_last;

  conv_channel_scheduler dut (
    .clk_i(clk), .rst_i(rst), .cfg_cin_i(cfg_cin), .cfg_cout_i(cfg_cout),
    .start_i(start), .busy_o(busy), .done_o(done), .err_o(err),
    .eng_start_o(eng_start), .eng_clear_o(eng_clear),
    .eng_in_sel_o(eng_in_sel), .eng_k_sel_o(eng_k_sel),
    .eng_pixel_i(eng_pixel), .eng_valid_i(eng_valid), .eng_done_i(eng_done),
    .res_data_o(res_data), .res_valid_o(res_valid), .res_ready_i(res_ready),
    .res_oc_o(res_oc), .res_last_o(res_last)
  );

  int n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // engine model + result sink, both sampled/driven on the falling edge
  int mode = 0;
  int pass_cnt[8];
  int pass_no = 0, tb_cin = 1;
  int e_st = 0, e_i = 0, e_n = 0, e_ic = 0, e_oc = 0;
  int n_start = 0, n_done = 0, viol = 0;
  int k_log[$], in_log[$];
  logic [31:0] q_data[$];
  int q_oc[$], q_last[$];
  logic rdy_tog = 1'b0;
  logic held_v = 1'b0, held_l = 1'b0;
  logic [31:0] held_d = '0;
  logic [1:0] held_oc = '0;

  function automatic logic [31:0] pix_val(input int i);
    case (mode)
      1:       return 32'((e_ic + 1) * (e_oc + 1));
      2:       return (e_ic == 0) ? 32'h7fff_ffff : 32'd1;
      default: return 32'(i + 1);
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      e_st = 0; eng_valid = 1'b0; eng_done = 1'b0; eng_pixel = '0;
      res_ready = 1'b1; held_v = 1'b0;
    end else begin
      if (eng_start) begin
        n_start++;
        k_log.push_back(int'(eng_k_sel));
        in_log.push_back(int'(eng_in_sel));
        if (eng_done || eng_clear) viol++;
      end
      if (done) n_done++;
      case (e_st)
        0: if (eng_start) begin
          e_st = 1; e_i = 0; e_n = pass_cnt[pass_no];
          e_ic = int'(eng_in_sel);
          e_oc = (int'(eng_k_sel) - int'(eng_in_sel)) / tb_cin;
        end
        1: if (e_i < e_n) begin
          eng_valid = 1'b1; eng_pixel = pix_val(e_i); e_i++;
        end else begin
          eng_valid = 1'b0; eng_done = 1'b1; e_st = 2;
        end
        default: if (eng_clear) begin
          eng_done = 1'b0; e_st = 0;
          if (pass_no < 7) pass_no++;
        end
      endcase
      res_ready = rdy_tog ? ~res_ready : 1'b1;
      if (held_v) begin
        chk("stall_valid", 32'(res_valid), 32'd1);
        chk("stall_data", res_data, held_d);
        chk("stall_oc", 32'(res_oc), 32'(held_oc));
        chk("stall_last", 32'(res_last), 32'(held_l));
      end
      held_v = 1'b0;
      if (res_valid) begin
        if (res_ready) begin
          q_data.push_back(res_data);
          q_oc.push_back(int'(res_oc));
          q_last.push_back(int'(res_last));
        end else begin
          held_v = 1'b1; held_d = res_data; held_oc = res_oc; held_l = res_last;
        end
      end
    end
  end

  task automatic set_cnt(input int a, input int b);
    for (int i = 0; i < 8; i++) pass_cnt[i] = 9;
    pass_cnt[0] = a;
    pass_cnt[1] = b;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_estart"}, 32'(eng_start), 0);
    chk({tag, "_eclear"}, 32'(eng_clear), 0);
    chk({tag, "_rvalid"}, 32'(res_valid), 0);
    chk({tag, "_rlast"}, 32'(res_last), 0);
    chk({tag, "_roc"}, 32'(res_oc), 0);
    chk({tag, "_insel"}, 32'(eng_in_sel), 0);
    chk({tag, "_ksel"}, 32'(eng_k_sel), 0);
  endtask

  task automatic run_layer(input int cin, input int cout, input bit ok, input bit poke,
                           output logic err_at_done);
    int cyc, d0;
    q_data.delete(); q_oc.delete(); q_last.delete();
    k_log.delete(); in_log.delete();
    pass_no = 0; tb_cin = (cin > 0) ? cin : 1; n_start = 0; d0 = n_done;
    cfg_cin = 3'(cin); cfg_cout = 3'(cout);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 1);
    if (ok) chk("first_eng_start", 32'(eng_start), 1);
    else    chk("reject_done_next", 32'(done), 1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      start = (poke && cyc == 20);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 0, 1);
    else       chk("busy_at_done", 32'(busy), 1);
    err_at_done = err;
    @(negedge clk);
    chk("busy_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
    repeat (3) @(negedge clk);
    chk("one_done", 32'(n_done - d0), 1);
  endtask

  logic e;
  int cyc;

  initial begin
    set_cnt(9, 9);
    repeat (3) @(negedge clk);
    chk_reset_outs("rst");
    rst = 1'b0;
    @(negedge clk);

    // single channel, pixels 1..9
    mode = 0;
    run_layer(1, 1, 1'b1, 1'b0, e);
    chk("t1_err", 32'(e), 0);
    chk("t1_beats", q_data.size(), 9);
    for (int i = 0; i < 9 && i < q_data.size(); i++) begin
      chk("t1_data", q_data[i], 32'(i + 1));
      chk("t1_last", q_last[i], (i == 8) ? 1 : 0);
    end

    // 3 in x 2 out, start poked while busy
    mode = 1;
    run_layer(3, 2, 1'b1, 1'b1, e);
    chk("t2_err", 32'(e), 0);
    chk("t2_beats", q_data.size(), 18);
    for (int i = 0; i < 18 && i < q_data.size(); i++) begin
      chk("t2_data", q_data[i], (i < 9) ? 32'd6 : 32'd12);
      chk("t2_oc", q_oc[i], (i < 9) ? 0 : 1);
    end
    chk("t2_nstart", k_log.size(), 6);
    for (int i = 0; i < 6 && i < k_log.size(); i++) begin
      chk("t2_ksel", k_log[i], i);
      chk("t2_insel", in_log[i], i % 3);
    end

    // ready toggling during drain
    mode = 0; rdy_tog = 1'b1;
    run_layer(1, 2, 1'b1, 1'b0, e);
    rdy_tog = 1'b0;
    chk("t3_beats", q_data.size(), 18);
    for (int i = 0; i < 18 && i < q_data.size(); i++) begin
      chk("t3_data", q_data[i], 32'((i % 9) + 1));
      chk("t3_oc", q_oc[i], i / 9);
      chk("t3_last", q_last[i], (i % 9 == 8) ? 1 : 0);
    end

    // short pass (8) then long pass (10)
    set_cnt(8, 10);
    run_layer(1, 2, 1'b1, 1'b0, e);
    set_cnt(9, 9);
    chk("t4_err", 32'(e), 1);
    chk("t4_beats", q_data.size(), 18);
    for (int i = 0; i < 18 && i < q_data.size(); i++) begin
      if (i != 8) chk("t4_data", q_data[i], 32'((i % 9) + 1));
    end

    // rejected configurations
    run_layer(0, 1, 1'b0, 1'b0, e);
    chk("t5_err", 32'(e), 1);
    chk("t5_nstart", n_start, 0);
    chk("t5_beats", q_data.size(), 0);
    run_layer(1, 5, 1'b0, 1'b0, e);
    chk("t5b_err", 32'(e), 1);
    chk("t5b_nstart", n_start, 0);

    // accumulation wrap; err cleared by a good start
    mode = 2;
    run_layer(2, 1, 1'b1, 1'b0, e);
    chk("t6_err", 32'(e), 0);
    chk("t6_beats", q_data.size(), 9);
    for (int i = 0; i < 9 && i < q_data.size(); i++)
      chk("t6_wrap", q_data[i], 32'h8000_0000);

    // reset in the middle of oc=1 collection
    mode = 0; set_cnt(8, 9);
    pass_no = 0; tb_cin = 2; n_start = 0;
    cfg_cin = 3'd2; cfg_cout = 3'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (n_start < 3 && cyc < 500) begin @(negedge clk); cyc++; end
    chk("t7_reach_oc1", n_start, 3);
    repeat (3) @(negedge clk);
    chk("t7_pre_busy", 32'(busy), 1);
    chk("t7_pre_err", 32'(err), 1);
    chk("t7_pre_ksel", 32'(eng_k_sel), 2);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("t7");
    rst = 1'b0;
    set_cnt(9, 9);
    @(negedge clk);
    run_layer(1, 1, 1'b1, 1'b0, e);
    chk("t7_err", 32'(e), 0);
    chk("t7_beats", q_data.size(), 9);
    for (int i = 0; i < 9 && i < q_data.size(); i++)
      chk("t7_data", q_data[i], 32'(i + 1));

    chk("eng_overlap", viol, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
